// File: rtl/instr_encoder.sv
// RV32IM instruction encoder: packs field-level requests into 32-bit words and
// streams them through a small FIFO into instruction memory at consecutive addresses.
module instr_encoder #(
   parameter int ADDR_W     = 10,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              prog_start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic              prog_end,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_class,
   input  logic [2:0]        in_funct3,
   input  logic              in_alt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [20:0]       in_imm,
   output logic              wr_en,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [7:0]        err_cnt,
   output logic [15:0]       instr_cnt
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   // Returns {legal, word}; an illegal request still yields a (discarded) word.
   function automatic logic [32:0] encode(
      input logic [2:0]  cls,
      input logic [2:0]  f3,
      input logic        alt,
      input logic [4:0]  rd,
      input logic [4:0]  rs1,
      input logic [4:0]  rs2,
      input logic [20:0] imm
   );
      logic        legal_s;
      logic [31:0] word_s;
      logic        fit12_s;
      logic        fit13_s;
      logic        shift_s;
      fit12_s = (imm[20:11] == 10'h000) || (imm[20:11] == 10'h3FF);
      fit13_s = (imm[20:12] == 9'h000) || (imm[20:12] == 9'h1FF);
      shift_s = (f3 == 3'b001) || (f3 == 3'b101);
      case (cls)
         3'd0: begin
            legal_s = !(alt && (f3 != 3'b000) && (f3 != 3'b101));
            word_s  = {1'b0, alt, 5'b00000, rs2, rs1, f3, rd, 7'b0110011};
         end
         3'd1: begin
            if (shift_s) begin
               legal_s = (imm[20:5] == 16'h0000) && !(alt && (f3 != 3'b101));
               word_s  = {1'b0, alt, 5'b00000, imm[4:0], rs1, f3, rd, 7'b0010011};
            end else begin
               legal_s = fit12_s && !alt;
               word_s  = {imm[11:0], rs1, f3, rd, 7'b0010011};
            end
         end
         3'd2: begin
            legal_s = fit12_s && (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
            word_s  = {imm[11:0], rs1, f3, rd, 7'b0000011};
         end
         3'd3: begin
            legal_s = fit12_s && (f3 < 3'b011);
            word_s  = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
         end
         3'd4: begin
            legal_s = fit13_s && !imm[0] && (f3 != 3'b010) && (f3 != 3'b011);
            word_s  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
         end
         3'd5: begin
            legal_s = !imm[0];
            word_s  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
         end
         3'd6: begin
            legal_s = fit12_s && (f3 == 3'b000);
            word_s  = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
         end
         3'd7: begin
            legal_s = !alt;
            word_s  = {7'b0000001, rs2, rs1, f3, rd, 7'b0110011};
         end
         default: begin
            legal_s = 1'b0;
            word_s  = 32'h0000_0000;
         end
      endcase
      return {legal_s, word_s};
   endfunction

   logic [1:0]        state_r;
   logic [PTR_W:0]    count_r;
   logic [PTR_W-1:0]  rd_ptr_r;
   logic [PTR_W-1:0]  wr_ptr_r;
   logic [31:0]       mem_r [FIFO_DEPTH];
   logic [ADDR_W-1:0] addr_r;
   logic              done_r;
   logic              err_r;
   logic [7:0]        err_cnt_r;
   logic [15:0]       instr_cnt_r;

   logic [32:0] enc_s;
   logic        fifo_full_s;
   logic        fifo_empty_s;
   logic        accept_s;
   logic        push_s;
   logic        pop_s;

   // Combinational encode of whatever request is presented this cycle.
   always_comb begin
      enc_s = encode(in_class, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm);
   end

   assign fifo_full_s  = (count_r == FULL_CNT);
   assign fifo_empty_s = (count_r == '0);
   assign in_ready     = (state_r == ST_LOAD) && !fifo_full_s;
   assign accept_s     = in_valid && in_ready;
   assign push_s       = accept_s && enc_s[32];
   assign pop_s        = !fifo_empty_s && wr_ready;

   assign wr_en     = !fifo_empty_s;
   assign wr_addr   = addr_r;
   assign wr_data   = mem_r[rd_ptr_r];
   assign busy      = (state_r != ST_IDLE);
   assign done      = done_r;
   assign err       = err_r;
   assign err_cnt   = err_cnt_r;
   assign instr_cnt = instr_cnt_r;

   // FIFO pointers and occupancy; reset discards queued words at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_r <= '0;
         wr_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + (PTR_W+1)'(1);
            2'b01:   count_r <= count_r - (PTR_W+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // FIFO storage; contents are only observed while occupancy is non-zero.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= enc_s[31:0];
      end
   end

   // Program sequencing, write address and status counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         addr_r      <= '0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
         err_cnt_r   <= 8'd0;
         instr_cnt_r <= 16'd0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (prog_start) begin
                  state_r     <= ST_LOAD;
                  addr_r      <= start_addr;
                  err_r       <= 1'b0;
                  err_cnt_r   <= 8'd0;
                  instr_cnt_r <= 16'd0;
               end
            end
            ST_LOAD: begin
               if (prog_end) begin
                  state_r <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (fifo_empty_s) begin
                  state_r <= ST_IDLE;
                  done_r  <= 1'b1;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
         if (pop_s) begin
            addr_r <= addr_r + ADDR_W'(1);
            if (instr_cnt_r != 16'hFFFF) begin
               instr_cnt_r <= instr_cnt_r + 16'd1;
            end
         end
         if (accept_s && !enc_s[32]) begin
            err_r <= 1'b1;
            if (err_cnt_r != 8'hFF) begin
               err_cnt_r <= err_cnt_r + 8'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder: a queue-based reference model predicts every
// output each cycle, with directed sequences and hand-encoded words pinning the model.
module tb_instr_encoder;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          prog_start = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic          prog_end = 1'b0;
   logic          in_valid = 1'b0;
   logic [2:0]    in_class = 3'd0;
   logic [2:0]    in_funct3 = 3'd0;
   logic          in_alt = 1'b0;
   logic [4:0]    in_rd = 5'd0;
   logic [4:0]    in_rs1 = 5'd0;
   logic [4:0]    in_rs2 = 5'd0;
   logic [20:0]   in_imm = 21'd0;
   logic          wr_ready = 1'b0;
   logic          in_ready;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;
   logic          busy;
   logic          done;
   logic          err;
   logic [7:0]    err_cnt;
   logic [15:0]   instr_cnt;

   instr_encoder #(.ADDR_W(AW), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .prog_start(prog_start), .start_addr(start_addr),
      .prog_end(prog_end), .in_valid(in_valid), .in_ready(in_ready), .in_class(in_class),
      .in_funct3(in_funct3), .in_alt(in_alt), .in_rd(in_rd), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_imm(in_imm), .wr_en(wr_en), .wr_ready(wr_ready),
      .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .err(err),
      .err_cnt(err_cnt), .instr_cnt(instr_cnt)
   );

   always #5 clk = ~clk;

   int vecs = 0;
   int fails = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      vecs++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference encoder built straight from the field placement rules.
   function automatic logic [32:0] ref_enc(input int cls, input int f3, input int alt,
                                           input int rd, input int rs1, input int rs2,
                                           input int imm);
      int w;
      bit ok;
      bit f12;
      int base;
      f12  = (imm >= -2048) && (imm <= 2047);
      base = (rs1 << 15) | (f3 << 12) | (rd << 7);
      case (cls)
         0: begin
            ok = !(alt != 0 && f3 != 0 && f3 != 5);
            w  = (alt << 30) | (rs2 << 20) | base | 32'h33;
         end
         1: begin
            if (f3 == 1 || f3 == 5) begin
               ok = (imm >= 0) && (imm <= 31) && !(alt != 0 && f3 != 5);
               w  = (alt << 30) | ((imm & 32'h1F) << 20) | base | 32'h13;
            end else begin
               ok = f12 && (alt == 0);
               w  = ((imm & 32'hFFF) << 20) | base | 32'h13;
            end
         end
         2: begin
            ok = f12 && !(f3 == 3 || f3 == 6 || f3 == 7);
            w  = ((imm & 32'hFFF) << 20) | base | 32'h03;
         end
         3: begin
            ok = f12 && (f3 < 3);
            w  = (((imm >>> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
               | ((imm & 32'h1F) << 7) | 32'h23;
         end
         4: begin
            ok = (imm >= -4096) && (imm <= 4095) && ((imm & 1) == 0) && f3 != 2 && f3 != 3;
            w  = (((imm >>> 12) & 1) << 31) | (((imm >>> 5) & 32'h3F) << 25) | (rs2 << 20)
               | (rs1 << 15) | (f3 << 12) | (((imm >>> 1) & 32'hF) << 8)
               | (((imm >>> 11) & 1) << 7) | 32'h63;
         end
         5: begin
            ok = (imm & 1) == 0;
            w  = (((imm >>> 20) & 1) << 31) | (((imm >>> 1) & 32'h3FF) << 21)
               | (((imm >>> 11) & 1) << 20) | (((imm >>> 12) & 32'hFF) << 12)
               | (rd << 7) | 32'h6F;
         end
         6: begin
            ok = f12 && (f3 == 0);
            w  = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
         end
         default: begin
            ok = (alt == 0);
            w  = (1 << 25) | (rs2 << 20) | base | 32'h33;
         end
      endcase
      return {ok, w[31:0]};
   endfunction

   // Model state: program phase (0 idle, 1 loading, 2 draining) and queued words.
   int            m_phase = 0;
   logic [31:0]   mq[$];
   logic [AW-1:0] m_addr = '0;
   bit            m_done = 1'b0;
   bit            m_err = 1'b0;
   int            m_errcnt = 0;
   int            m_icnt = 0;

   task automatic model_reset();
      m_phase = 0; mq.delete(); m_addr = '0; m_done = 1'b0;
      m_err = 1'b0; m_errcnt = 0; m_icnt = 0;
   endtask

   task automatic model_edge();
      bit acc, pop, fin;
      int sz;
      logic [32:0] e;
      sz  = mq.size();
      acc = in_valid && (m_phase == 1) && (sz < 4);
      pop = (sz > 0) && wr_ready;
      fin = (m_phase == 2) && (sz == 0);
      e   = ref_enc(int'(in_class), int'(in_funct3), int'(in_alt), int'(in_rd),
                    int'(in_rs1), int'(in_rs2), int'($signed(in_imm)));
      m_done = fin;
      if (m_phase == 0 && prog_start) begin
         m_phase = 1; m_addr = start_addr; m_err = 1'b0; m_errcnt = 0; m_icnt = 0;
      end else if (m_phase == 1 && prog_end) begin
         m_phase = 2;
      end else if (fin) begin
         m_phase = 0;
      end
      if (pop) begin
         mq.delete(0);
         m_addr = m_addr + 10'd1;
         if (m_icnt < 65535) m_icnt++;
      end
      if (acc) begin
         if (e[32]) mq.push_back(e[31:0]);
         else begin
            m_err = 1'b1;
            if (m_errcnt < 255) m_errcnt++;
         end
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_edge();
   end

   bit cmp_en = 1'b0;

   // Per-cycle comparison of every output against the model.
   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         chk("in_ready", in_ready, (m_phase == 1) && (mq.size() < 4));
         chk("wr_en", wr_en, mq.size() > 0);
         chk("wr_addr", wr_addr, m_addr);
         if (mq.size() > 0) chk("wr_data", wr_data, mq[0]);
         chk("busy", busy, m_phase != 0);
         chk("done", done, m_done);
         chk("err", err, m_err);
         chk("err_cnt", err_cnt, m_errcnt);
         chk("instr_cnt", instr_cnt, m_icnt);
      end
   end

   task automatic send(input int cls, input int f3, input int alt, input int rd,
                       input int rs1, input int rs2, input int imm);
      bit a;
      in_valid = 1'b1; in_class = cls[2:0]; in_funct3 = f3[2:0]; in_alt = alt[0];
      in_rd = rd[4:0]; in_rs1 = rs1[4:0]; in_rs2 = rs2[4:0]; in_imm = imm[20:0];
      for (int k = 0; k < 100; k++) begin
         a = (m_phase == 1) && (mq.size() < 4);
         @(negedge clk);
         if (a) break;
      end
   endtask

   task automatic pulse_start(input int addr);
      start_addr = addr[AW-1:0]; prog_start = 1'b1;
      @(negedge clk);
      prog_start = 1'b0;
   endtask

   task automatic finish_prog(input bit rnd);
      int k;
      in_valid = 1'b0; prog_end = 1'b1;
      @(negedge clk);
      prog_end = 1'b0;
      for (k = 0; k < 300; k++) begin
         wr_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         @(negedge clk);
         if (done) break;
      end
      chk("done_within_bound", k < 300, 1);
   endtask

   function automatic int rand_imm();
      int edges[13];
      edges = '{2047, 2048, -2048, -2049, 4095, 4096, -4096, -4097, 31, 32, 1048575, -1048576, 4094};
      case ($urandom_range(0, 4))
         0: return $urandom_range(0, 80) - 40;
         1: return edges[$urandom_range(0, 12)];
         2: return int'($signed(21'($urandom)));
         3: return $urandom_range(0, 31);
         default: return 2 * ($urandom_range(0, 4000) - 2000);
      endcase
   endfunction

   logic [32:0] e;

   initial begin
      #2 rst_n = 1'b0;
      #2;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_instr_cnt", instr_cnt, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      cmp_en = 1'b1;

      chk("ref_add",  ref_enc(0, 0, 0, 3, 1, 2, 0),    {1'b1, 32'h002081B3});
      chk("ref_sub",  ref_enc(0, 0, 1, 3, 1, 2, 0),    {1'b1, 32'h402081B3});
      chk("ref_addi", ref_enc(1, 0, 0, 5, 0, 0, -1),   {1'b1, 32'hFFF00293});
      chk("ref_beq",  ref_enc(4, 0, 0, 0, 1, 2, 8),    {1'b1, 32'h00208463});
      chk("ref_jal",  ref_enc(5, 0, 0, 1, 0, 0, 2048), {1'b1, 32'h001000EF});
      chk("ref_mul",  ref_enc(7, 0, 0, 3, 1, 2, 0),    {1'b1, 32'h022081B3});
      e = ref_enc(4, 0, 0, 0, 1, 2, 3);
      chk("ref_br_odd_illegal", e[32], 0);
      e = ref_enc(1, 0, 0, 1, 1, 0, 2048);
      chk("ref_addi_range_illegal", e[32], 0);

      // Directed: ADD/SUB at 0x10, then FIFO backpressure with five requests.
      pulse_start(32'h10);
      wr_ready = 1'b0;
      send(0, 0, 0, 3, 1, 2, 0);
      send(0, 0, 1, 3, 1, 2, 0);
      in_valid = 1'b0;
      chk("add_wr_en", wr_en, 1);
      chk("add_addr", wr_addr, 32'h10);
      chk("add_data", wr_data, 32'h002081B3);
      wr_ready = 1'b1;
      @(negedge clk);
      chk("sub_addr", wr_addr, 32'h11);
      chk("sub_data", wr_data, 32'h402081B3);
      @(negedge clk);
      wr_ready = 1'b0;
      send(1, 0, 0, 5, 0, 0, -1);
      send(4, 0, 0, 0, 1, 2, 8);
      send(5, 0, 0, 1, 0, 0, 2048);
      send(7, 0, 0, 3, 1, 2, 0);
      chk("full_in_ready", in_ready, 0);
      chk("full_head", wr_data, 32'hFFF00293);
      wr_ready = 1'b1;
      send(0, 0, 0, 3, 1, 2, 0);
      finish_prog(1'b0);

      // Illegal requests are dropped and counted; next program clears the status.
      pulse_start(32'h20);
      send(4, 0, 0, 0, 1, 2, 3);
      send(1, 0, 0, 1, 1, 0, 2048);
      finish_prog(1'b0);
      chk("err_set", err, 1);
      chk("err_cnt_two", err_cnt, 2);
      pulse_start(32'h30);
      chk("err_cleared", err, 0);
      chk("err_cnt_cleared", err_cnt, 0);
      finish_prog(1'b0);

      // Address wrap at the top of the word space.
      pulse_start(32'h3FF);
      wr_ready = 1'b0;
      send(0, 0, 0, 3, 1, 2, 0);
      send(7, 0, 0, 3, 1, 2, 0);
      in_valid = 1'b0;
      chk("wrap_first_addr", wr_addr, 32'h3FF);
      wr_ready = 1'b1;
      @(negedge clk);
      chk("wrap_second_addr", wr_addr, 0);
      chk("wrap_second_data", wr_data, 32'h022081B3);
      @(negedge clk);
      chk("wrap_instr_cnt", instr_cnt, 2);
      finish_prog(1'b0);

      // Randomized programs; prog_end in IDLE and prog_start in LOAD must be ignored.
      for (int p = 0; p < 8; p++) begin
         prog_end = 1'b1;
         @(negedge clk);
         prog_end = 1'b0;
         pulse_start(int'($urandom_range(0, 1023)));
         for (int c = 0; c < 80; c++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_class   = 3'($urandom);
            in_funct3  = 3'($urandom);
            in_alt     = ($urandom_range(0, 4) == 0);
            in_rd      = 5'($urandom);
            in_rs1     = 5'($urandom);
            in_rs2     = 5'($urandom);
            in_imm     = 21'(rand_imm());
            wr_ready   = ($urandom_range(0, 2) != 0);
            prog_start = ($urandom_range(0, 19) == 0);
            start_addr = 10'($urandom);
            @(negedge clk);
         end
         prog_start = 1'b0;
         in_valid   = 1'b1;
         in_class   = 3'd0;
         in_alt     = 1'b0;
         prog_end   = 1'b1;
         @(negedge clk);
         prog_end = 1'b0;
         finish_prog(1'b1);
      end

      // Reset in the middle of a stall drops queued words immediately.
      pulse_start(32'h40);
      wr_ready = 1'b0;
      send(0, 0, 0, 3, 1, 2, 0);
      send(7, 0, 0, 3, 1, 2, 0);
      send(1, 0, 0, 5, 0, 0, -1);
      in_valid = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("midrst_wr_en", wr_en, 0);
      chk("midrst_in_ready", in_ready, 0);
      chk("midrst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_wr_en", wr_en, 0);
      chk("post_rst_wr_addr", wr_addr, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end
endmodule
